// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS Execute stage.
// One shift-add or restoring shift-subtract step per cycle; sign fix-up and HI/LO write in FIX.
//
// state  | meaning
// S_IDLE | waiting for StartE; MTHI/MTLO writes land here
// S_RUN  | WIDTH iteration steps on operand magnitudes
// S_FIX  | sign correction, HI/LO write, DoneE next cycle
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [1:0]       MoveToE,
    input  logic             AbortE,
    input  logic             MfReqD,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             BusyE,
    output logic             DoneE,
    output logic             DivZeroE,
    output logic             StallMD
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             signed_in, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_r;
    logic [WIDTH-1:0] div_sub;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_in = ~OpE[0];
    assign a_neg_in  = signed_in & SrcAE[WIDTH-1];
    assign b_neg_in  = signed_in & SrcBE[WIDTH-1];
    assign a_abs     = a_neg_in ? -SrcAE : SrcAE;
    assign b_abs     = b_neg_in ? -SrcBE : SrcBE;

    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

    // Partial remainder stays below the divisor, so the W-bit difference is exact when taken.
    assign div_r   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ok  = (div_r >= {1'b0, m_q});
    assign div_sub = div_r[WIDTH-1:0] - m_q;

    assign prod_fix = q_neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix  = q_neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = r_neg_q ? -acc_hi_q : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (StartE) begin
                    if (!AbortE) begin
                        is_div_d = OpE[1];
                        q_neg_d  = a_neg_in ^ b_neg_in;
                        r_neg_d  = a_neg_in;
                        a_raw_d  = SrcAE;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        if (OpE[1]) begin
                            m_d      = b_abs;
                            acc_lo_d = a_abs;
                        end else begin
                            m_d      = a_abs;
                            acc_lo_d = b_abs;
                        end
                        state_d = S_RUN;
                    end
                end else begin
                    if (MoveToE[1]) hi_d = SrcAE;
                    if (MoveToE[0]) lo_d = SrcAE;
                end
            end
            S_RUN: begin
                if (AbortE) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = div_ok ? div_sub : div_r[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!AbortE) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (m_q == '0) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign HiOut    = hi_q;
    assign LoOut    = lo_q;
    assign BusyE    = (state_q != S_IDLE);
    assign DoneE    = done_q;
    assign DivZeroE = dz_q;
    assign StallMD  = BusyE & (MfReqD | StartE | (|MoveToE));

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: scoreboard of expected HI/LO/DivZero per operation,
// plus directed checks of busy length, stall, abort and asynchronous reset.
module tb_mips_muldiv_unit;

    logic        CLK;
    logic        RST;
    logic        StartE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [1:0]  MoveToE;
    logic        AbortE;
    logic        MfReqD;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        BusyE;
    logic        DoneE;
    logic        DivZeroE;
    logic        StallMD;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          checks;
    int          errors;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .StartE   (StartE),
        .OpE      (OpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .MoveToE  (MoveToE),
        .AbortE   (AbortE),
        .MfReqD   (MfReqD),
        .HiOut    (HiOut),
        .LoOut    (LoOut),
        .BusyE    (BusyE),
        .DoneE    (DoneE),
        .DivZeroE (DivZeroE),
        .StallMD  (StallMD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            2'b01: begin
                u = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = u;
            end
            2'b10: begin
                if (b == 32'h0) begin
                    e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'h0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'h0) begin
                    e.dz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Every DoneE pulse retires the oldest expected result.
    always @(negedge CLK) begin
        if (RST) begin
            if (DoneE) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_hi", HiOut, e.hi);
                    chk("sb_lo", LoOut, e.lo);
                    chk("sb_dz", DivZeroE, e.dz);
                    exp_hi = e.hi;
                    exp_lo = e.lo;
                end
            end else if (DivZeroE) begin
                chk("dz_without_done", 64'd1, 64'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] mv);
        OpE = op; SrcAE = a; SrcBE = b; MoveToE = mv; StartE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        StartE = 1'b0; MoveToE = 2'b00;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mv, input bit stall);
        int busy_n;
        bit seen;
        sb.push_back(model(op, a, b));
        start_op(op, a, b, mv);
        if (stall) begin
            MfReqD = 1'b1; MoveToE = 2'b10; SrcAE = 32'h5555_5555;
        end
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (i > 0) @(negedge CLK);
            if (DoneE) begin
                seen = 1'b1;
                chk("busy_cycles", 64'(busy_n), 64'd33);
                if (stall) chk("stall_done", StallMD, 1'b0);
            end else if (BusyE) begin
                busy_n++;
                chk("hold_hi", HiOut, exp_hi);
                chk("hold_lo", LoOut, exp_lo);
                if (stall) chk("stall_busy", StallMD, 1'b1);
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        MfReqD = 1'b0; MoveToE = 2'b00;
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_hi = '0; exp_lo = '0;
        RST = 1'b0; StartE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0;
        MoveToE = 2'b00; AbortE = 1'b0; MfReqD = 1'b1;

        repeat (2) @(negedge CLK);
        chk("rst_hi", HiOut, 32'h0);
        chk("rst_lo", LoOut, 32'h0);
        chk("rst_busy", BusyE, 1'b0);
        chk("rst_done", DoneE, 1'b0);
        chk("rst_dz", DivZeroE, 1'b0);
        chk("rst_stall", StallMD, 1'b0);
        RST = 1'b1; MfReqD = 1'b0;
        @(negedge CLK);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0);
        @(negedge CLK);
        chk("done_once", DoneE, 1'b0);

        // Back-to-back from here on; the MULT also carries a move that must be dropped.
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 2'b11, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0);
        run_op(2'b11, 32'h0000_1234, 32'h0, 2'b00, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 1) a = -a;
            run_op(op, a, b, 2'b00, 1'b0);
        end

        run_op(2'b11, 32'd100, 32'd7, 2'b00, 1'b1);
        @(negedge CLK);
        chk("mthi_not_applied", HiOut, exp_hi);

        OpE = 2'b01; SrcAE = 32'd3; SrcBE = 32'd4; StartE = 1'b1; AbortE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        StartE = 1'b0; AbortE = 1'b0;
        chk("abort_start_idle", BusyE, 1'b0);

        SrcAE = 32'h0000_AAAA; MoveToE = 2'b01;
        @(posedge CLK);
        @(negedge CLK);
        MoveToE = 2'b00;
        exp_lo = 32'h0000_AAAA;
        chk("mtlo", LoOut, exp_lo);
        chk("mtlo_hi_kept", HiOut, exp_hi);

        start_op(2'b01, 32'd3, 32'd4, 2'b00);
        for (int n = 1; n < 10; n++) @(negedge CLK);
        chk("abort_busy_pre", BusyE, 1'b1);
        AbortE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        AbortE = 1'b0;
        chk("abort_busy", BusyE, 1'b0);
        chk("abort_lo", LoOut, 32'h0000_AAAA);
        chk("abort_done", DoneE, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            chk("abort_no_done", DoneE, 1'b0);
        end

        start_op(2'b01, 32'd3, 32'd4, 2'b00);
        repeat (5) @(negedge CLK);
        MfReqD = 1'b1;
        #1;
        chk("pre_rst_stall", StallMD, 1'b1);
        RST = 1'b0;
        #1;
        chk("arst_busy", BusyE, 1'b0);
        chk("arst_stall", StallMD, 1'b0);
        chk("arst_hi", HiOut, 32'h0);
        chk("arst_lo", LoOut, 32'h0);
        chk("arst_done", DoneE, 1'b0);
        chk("arst_dz", DivZeroE, 1'b0);
        exp_hi = '0; exp_lo = '0;
        @(negedge CLK);
        RST = 1'b1; MfReqD = 1'b0;
        @(negedge CLK);

        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 2'b00, 1'b0);
        @(negedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
